// File: rtl/wb_irq_ctrl.sv
// wb_irq_ctrl: Wishbone B3 classic slave that synchronises raw peripheral
// interrupt lines, latches them into sticky pending bits (level or rising
// edge), masks them onto a registered CPU irq vector, and provides a
// software force register plus a one-shot countdown timer.
module wb_irq_ctrl #(
  parameter int NUM_IRQ     = 32,
  parameter int SYNC_STAGES = 2,
  parameter int TIMER_BIT   = 31,
  parameter int TIMER_WIDTH = 24
) (
  input  logic               wb_clk_i,
  input  logic               wb_rst_i,
  input  logic [4:0]         wb_adr_i,
  input  logic [31:0]        wb_dat_i,
  input  logic [3:0]         wb_sel_i,
  input  logic               wb_we_i,
  input  logic               wb_cyc_i,
  input  logic               wb_stb_i,
  output logic [31:0]        wb_dat_o,
  output logic               wb_ack_o,
  output logic               wb_err_o,
  input  logic [NUM_IRQ-1:0] irq_i,
  output logic [NUM_IRQ-1:0] irq_o
);

  localparam logic [2:0] REG_PEND   = 3'd0;
  localparam logic [2:0] REG_MASK   = 3'd1;
  localparam logic [2:0] REG_EDGE   = 3'd2;
  localparam logic [2:0] REG_STATUS = 3'd3;
  localparam logic [2:0] REG_FORCE  = 3'd4;
  localparam logic [2:0] REG_TIMER  = 3'd5;

  logic [NUM_IRQ-1:0]     sync_p [SYNC_STAGES];
  logic [NUM_IRQ-1:0]     prev_p;
  logic [NUM_IRQ-1:0]     sync_s;
  logic [NUM_IRQ-1:0]     pend;
  logic [NUM_IRQ-1:0]     mask;
  logic [NUM_IRQ-1:0]     edge_mode;
  logic [TIMER_WIDTH-1:0] count;

  logic                   req;
  logic                   mapped;
  logic                   wr_en;
  logic                   wr_pend;
  logic                   wr_mask;
  logic                   wr_edge;
  logic                   wr_force;
  logic                   wr_timer;
  logic                   timer_pulse;
  logic [NUM_IRQ-1:0]     wdat;
  logic [NUM_IRQ-1:0]     set_vec;
  logic [NUM_IRQ-1:0]     clr_vec;
  logic [NUM_IRQ-1:0]     timer_vec;
  logic [31:0]            rd_data;

  // Byte-lane offset bits carry no information for 32-bit registers.
  logic unused_adr;
  assign unused_adr = &{1'b0, wb_adr_i[1:0]};

  assign wdat   = wb_dat_i[NUM_IRQ-1:0];
  assign sync_s = sync_p[SYNC_STAGES-1];

  // Bus request qualification and register write decode; the ack/err cycle
  // itself never starts a new request.
  always_comb begin
    req      = wb_cyc_i & wb_stb_i & ~wb_ack_o & ~wb_err_o;
    mapped   = (wb_adr_i[4:3] != 2'b11);
    wr_en    = req & wb_we_i & mapped & (wb_sel_i == 4'hF);
    wr_pend  = wr_en & (wb_adr_i[4:2] == REG_PEND);
    wr_mask  = wr_en & (wb_adr_i[4:2] == REG_MASK);
    wr_edge  = wr_en & (wb_adr_i[4:2] == REG_EDGE);
    wr_force = wr_en & (wb_adr_i[4:2] == REG_FORCE);
    wr_timer = wr_en & (wb_adr_i[4:2] == REG_TIMER);
  end

  // Read mux; unused upper bits read as zero.
  always_comb begin
    rd_data = '0;
    case (wb_adr_i[4:2])
      REG_PEND:   rd_data = 32'(pend);
      REG_MASK:   rd_data = 32'(mask);
      REG_EDGE:   rd_data = 32'(edge_mode);
      REG_STATUS: rd_data = 32'(pend & mask);
      REG_TIMER:  rd_data = 32'(count);
      default:    rd_data = '0;
    endcase
  end

  // Pending set/clear terms; a reload on the expiring cycle suppresses the pulse.
  always_comb begin
    timer_pulse = (count == TIMER_WIDTH'(1)) & ~wr_timer;
    timer_vec   = NUM_IRQ'(timer_pulse) << TIMER_BIT;
    set_vec     = (sync_s & ~(edge_mode & prev_p))
                | (wr_force ? wdat : '0)
                | timer_vec;
    clr_vec     = wr_pend ? wdat : '0;
  end

  // Input synchroniser chain plus one-cycle-delayed copy for edge detection.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_p[i] <= '0;
      prev_p <= '0;
    end else begin
      sync_p[0] <= irq_i;
      for (int i = 1; i < SYNC_STAGES; i++) sync_p[i] <= sync_p[i-1];
      prev_p <= sync_s;
    end
  end

  // Interrupt state: sticky pending (set beats clear), mask, edge select, output vector.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      pend      <= '0;
      mask      <= '0;
      edge_mode <= '0;
      irq_o     <= '0;
    end else begin
      pend  <= (pend & ~clr_vec) | set_vec;
      irq_o <= pend & mask;
      if (wr_mask) mask <= wdat;
      if (wr_edge) edge_mode <= wdat;
    end
  end

  // One-shot countdown: load on write, decrement to zero, then idle.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      count <= '0;
    end else if (wr_timer) begin
      count <= wb_dat_i[TIMER_WIDTH-1:0];
    end else if (count != '0) begin
      count <= count - TIMER_WIDTH'(1);
    end
  end

  // Single-cycle ack/err response with registered read data.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      wb_ack_o <= 1'b0;
      wb_err_o <= 1'b0;
      wb_dat_o <= '0;
    end else begin
      wb_ack_o <= req & mapped;
      wb_err_o <= req & ~mapped;
      wb_dat_o <= (req & mapped & ~wb_we_i) ? rd_data : '0;
    end
  end

endmodule

// File: tb/tb_wb_irq_ctrl.sv
// tb_wb_irq_ctrl: directed and randomized bench for wb_irq_ctrl with a
// behavioural reference model checked on every falling clock edge.
module tb_wb_irq_ctrl;

  localparam int SYNC = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [4:0]  adr = '0;
  logic [31:0] dat = '0;
  logic [3:0]  sel = '0;
  logic        we  = 1'b0;
  logic        cyc = 1'b0;
  logic        stb = 1'b0;
  logic [31:0] dat_o;
  logic        ack;
  logic        err;
  logic [31:0] irq = '0;
  logic [31:0] irq_o;

  int checks = 0;
  int fails  = 0;
  logic [31:0] rdata;
  logic        rerr;
  logic        rand_done = 1'b0;

  wb_irq_ctrl #(.NUM_IRQ(32), .SYNC_STAGES(SYNC), .TIMER_BIT(31), .TIMER_WIDTH(24)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .wb_adr_i(adr), .wb_dat_i(dat), .wb_sel_i(sel),
    .wb_we_i(we), .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_dat_o(dat_o), .wb_ack_o(ack),
    .wb_err_o(err), .irq_i(irq), .irq_o(irq_o)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL global_timeout act=running exp=finished");
    $fatal(1, "timeout");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  logic [31:0] m_pend = '0, m_mask = '0, m_edge = '0, m_irqo = '0, m_dat = '0;
  logic        m_ack = 1'b0, m_err = 1'b0;
  int unsigned m_tmr = 0;
  logic [31:0] m_hist [0:SYNC];
  logic [31:0] m_s, m_pv, m_set, m_clr, m_rd;
  logic        m_req, m_map, m_wr, m_twr;
  int          m_idx;

  initial for (int k = 0; k <= SYNC; k++) m_hist[k] = '0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_pend = '0; m_mask = '0; m_edge = '0; m_irqo = '0; m_dat = '0;
      m_ack = 1'b0; m_err = 1'b0; m_tmr = 0;
      for (int k = 0; k <= SYNC; k++) m_hist[k] = '0;
    end else begin
      m_req = cyc && stb && !m_ack && !m_err;
      m_idx = int'(adr[4:2]);
      m_map = (m_idx < 6);
      m_wr  = m_req && we && m_map && (sel == 4'hF);
      m_twr = m_wr && (m_idx == 5);
      // synchronised line = irq_i seen SYNC edges back; prev = one further back
      m_s  = m_hist[SYNC-1];
      m_pv = m_hist[SYNC];
      for (int i = 0; i < 32; i++)
        m_set[i] = m_edge[i] ? (m_s[i] && !m_pv[i]) : m_s[i];
      if (m_wr && m_idx == 4) m_set = m_set | dat;
      if (m_tmr == 1 && !m_twr) m_set[31] = 1'b1;
      m_clr = (m_wr && m_idx == 0) ? dat : 32'h0;
      case (m_idx)
        0: m_rd = m_pend;
        1: m_rd = m_mask;
        2: m_rd = m_edge;
        3: m_rd = m_pend & m_mask;
        5: m_rd = m_tmr;
        default: m_rd = 32'h0;
      endcase
      m_irqo = m_pend & m_mask;
      m_pend = (m_pend & ~m_clr) | m_set;
      if (m_wr && m_idx == 1) m_mask = dat;
      if (m_wr && m_idx == 2) m_edge = dat;
      if (m_twr) m_tmr = dat & 32'h00FF_FFFF;
      else if (m_tmr > 0) m_tmr = m_tmr - 1;
      m_ack = m_req && m_map;
      m_err = m_req && !m_map;
      m_dat = (m_req && m_map && !we) ? m_rd : 32'h0;
      for (int k = SYNC; k > 0; k--) m_hist[k] = m_hist[k-1];
      m_hist[0] = irq;
    end
  end

  // Compare process: every falling edge outside reset.
  always @(negedge clk) begin
    if (!rst) begin
      chk("model_ack", {31'b0, ack}, {31'b0, m_ack});
      chk("model_err", {31'b0, err}, {31'b0, m_err});
      chk("model_dat", dat_o, m_dat);
      chk("model_irq", irq_o, m_irqo);
    end
  end

  // ---------------- bus helpers ----------------
  task automatic bus(input logic [4:0] a, input logic w, input logic [31:0] d, input logic [3:0] s);
    int n;
    @(negedge clk);
    adr = a; we = w; dat = d; sel = s; cyc = 1'b1; stb = 1'b1;
    n = 0;
    do begin
      @(posedge clk); #1; n++;
    end while (!(ack || err) && n < 4);
    if (!(ack || err)) begin
      checks++; fails++;
      $display("FAIL bus_timeout act=no_response exp=ack_or_err");
    end
    rdata = dat_o;
    rerr  = err;
    @(negedge clk);
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    bus(a, 1'b1, d, 4'hF);
  endtask

  task automatic rd(input string nm, input logic [4:0] a, input logic [31:0] exp);
    bus(a, 1'b0, 32'h0, 4'hF);
    chk(nm, rdata, exp);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [4:0]  ra;
    logic [31:0] rdv;
    logic [3:0]  rs;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ack", {31'b0, ack}, 32'h0);
    chk("rst_err", {31'b0, err}, 32'h0);
    chk("rst_irq", irq_o, 32'h0);
    chk("rst_dat", dat_o, 32'h0);
    rst = 1'b0;

    rd("rst_pend",   5'h00, 32'h0);
    rd("rst_mask",   5'h04, 32'h0);
    rd("rst_edge",   5'h08, 32'h0);
    rd("rst_status", 5'h0C, 32'h0);
    rd("rst_timer",  5'h14, 32'h0);
    bus(5'h18, 1'b0, 32'h0, 4'hF);
    chk("unmapped_err", {31'b0, rerr}, 32'h1);
    chk("unmapped_ack", {31'b0, ack}, 32'h0);
    @(posedge clk); #1;
    chk("unmapped_err_1cyc", {31'b0, err}, 32'h0);

    // level mode latency and re-pend
    wr(5'h04, 32'h4);
    wr(5'h08, 32'h0);
    @(negedge clk); irq[2] = 1'b1;
    repeat (3) @(posedge clk); #1;
    chk("lat_edge3", {31'b0, irq_o[2]}, 32'h0);
    @(posedge clk); #1;
    chk("lat_edge4", {31'b0, irq_o[2]}, 32'h1);
    wr(5'h00, 32'h4);
    rd("level_repend", 5'h00, 32'h4);
    @(negedge clk); irq[2] = 1'b0;
    repeat (3) @(posedge clk);
    wr(5'h00, 32'h4);
    chk("clr_irq_hold", {31'b0, irq_o[2]}, 32'h1);
    @(posedge clk); #1;
    chk("clr_irq_drop", {31'b0, irq_o[2]}, 32'h0);
    rd("clr_pend", 5'h00, 32'h0);

    // edge mode with mask off
    wr(5'h08, 32'h0008_0000);
    wr(5'h04, 32'h0);
    @(negedge clk); irq[19] = 1'b1;
    repeat (3) @(negedge clk);
    irq[19] = 1'b0;
    repeat (4) @(posedge clk);
    rd("edge_pend", 5'h00, 32'h0008_0000);
    chk("edge_masked_irq", irq_o, 32'h0);
    wr(5'h04, 32'h0008_0000);
    chk("unmask_pre", {31'b0, irq_o[19]}, 32'h0);
    @(posedge clk); #1;
    chk("unmask_post", {31'b0, irq_o[19]}, 32'h1);
    @(negedge clk); irq[19] = 1'b1;
    repeat (4) @(posedge clk);
    wr(5'h00, 32'h0008_0000);
    rd("edge_no_retrig", 5'h00, 32'h0);
    @(negedge clk); irq[19] = 1'b0;

    // set wins over simultaneous clear
    wr(5'h04, 32'h1);
    @(negedge clk); irq[0] = 1'b1;
    repeat (4) @(posedge clk);
    wr(5'h00, 32'h1);
    chk("setwins_a", {31'b0, irq_o[0]}, 32'h1);
    @(posedge clk); #1;
    chk("setwins_b", {31'b0, irq_o[0]}, 32'h1);
    rd("setwins_pend", 5'h00, 32'h1);
    @(negedge clk); irq[0] = 1'b0;
    repeat (3) @(posedge clk);
    wr(5'h00, 32'hFFFF_FFFF);

    // timer: plain expiry
    wr(5'h04, 32'h8000_0000);
    wr(5'h14, 32'd10);
    repeat (10) @(posedge clk); #1;
    chk("tmr_pre", {31'b0, irq_o[31]}, 32'h0);
    @(posedge clk); #1;
    chk("tmr_fire", {31'b0, irq_o[31]}, 32'h1);
    rd("tmr_idle", 5'h14, 32'h0);
    wr(5'h00, 32'h8000_0000);
    // timer: countdown reads and reload
    wr(5'h14, 32'd10);
    rd("tmr_cnt9", 5'h14, 32'd9);
    rd("tmr_cnt7", 5'h14, 32'd7);
    wr(5'h14, 32'd5);
    repeat (5) @(posedge clk); #1;
    chk("tmr_reload_pre", {31'b0, irq_o[31]}, 32'h0);
    @(posedge clk); #1;
    chk("tmr_reload_fire", {31'b0, irq_o[31]}, 32'h1);
    wr(5'h00, 32'h8000_0000);
    // timer: cancel
    wr(5'h14, 32'd10);
    wr(5'h14, 32'd0);
    repeat (15) @(posedge clk);
    rd("tmr_cancel", 5'h00, 32'h0);

    // force / status
    wr(5'h10, 32'h0000_1234);
    rd("force_pend", 5'h00, 32'h0000_1234);
    rd("force_read0", 5'h10, 32'h0);
    wr(5'h04, 32'h0000_0FF0);
    rd("status", 5'h0C, 32'h0000_0230);
    bus(5'h04, 1'b1, 32'hFFFF_FFFF, 4'h3);
    rd("partial_sel", 5'h04, 32'h0000_0FF0);
    wr(5'h00, 32'hFFFF_FFFF);

    // randomized phase
    fork
      begin
        for (int it = 0; it < 300; it++) begin
          ra  = 5'($urandom_range(0, 7)) << 2;
          rs  = ($urandom_range(0, 4) == 0) ? 4'($urandom) : 4'hF;
          rdv = $urandom;
          if (ra == 5'h14) rdv = $urandom_range(0, 20);
          if (ra == 5'h10) rdv = $urandom & $urandom & $urandom;
          bus(ra, 1'($urandom), rdv, rs);
        end
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          @(negedge clk);
          irq = irq ^ ($urandom & $urandom & $urandom & $urandom);
        end
      end
    join
    @(negedge clk); irq = '0;

    // asynchronous reset during a pending ack
    wr(5'h04, 32'h0000_FFFF);
    wr(5'h10, 32'h0000_FFFF);
    repeat (2) @(posedge clk); #1;
    chk("pre_rst_irq", irq_o & 32'h0000_FFFF, 32'h0000_FFFF);
    @(negedge clk);
    adr = 5'h00; we = 1'b0; sel = 4'hF; cyc = 1'b1; stb = 1'b1;
    @(posedge clk); #2;
    chk("pre_rst_ack", {31'b0, ack}, 32'h1);
    rst = 1'b1;
    #1;
    chk("async_rst_ack", {31'b0, ack}, 32'h0);
    chk("async_rst_err", {31'b0, err}, 32'h0);
    chk("async_rst_irq", irq_o, 32'h0);
    chk("async_rst_dat", dat_o, 32'h0);
    cyc = 1'b0; stb = 1'b0;
    @(negedge clk); rst = 1'b0;
    rd("post_rst_pend", 5'h00, 32'h0);
    rd("post_rst_mask", 5'h04, 32'h0);

    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
